// File: rtl/vend_mmio_bridge.sv
// Vending-machine MMIO bridge: coin/refund event FIFO, paced coin-return dispenser, timed vend outputs.
// Optional input debouncing is enabled by defining VEND_DEBOUNCE_EN.
module vend_mmio_bridge #(
    parameter int DEPTH    = 4,
    parameter int PRODUCTS = 1,
    parameter int TICK_DIV = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                refund,
    input  logic [31:0]         mem_addr,
    input  logic                mem_we,
    input  logic                mem_re,
    input  logic [31:0]         mem_wdata,
    output logic [31:0]         mem_rdata,
    output logic                nickel_out,
    output logic                dime_out,
    output logic                quarter_out,
    output logic [PRODUCTS-1:0] vend,
    output logic                tick,
    output logic                irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TICK_DIV);
    localparam int VW = $clog2(TICK_DIV + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_GAP} disp_state_t;

    logic [1:0] sel;
    logic       wr_status, wr_change, wr_vend;
    logic       unused_bits;

    assign sel       = mem_addr[3:2];
    assign wr_status = mem_we && (sel == 2'd1);
    assign wr_change = mem_we && (sel == 2'd2);
    assign wr_vend   = mem_we && (sel == 2'd3);
    assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:8]};

    logic [TW-1:0] div_q, div_d;
    assign tick = (div_q == TW'(TICK_DIV - 1));

    always_comb begin
        div_d = tick ? '0 : div_q + TW'(1);
    end

    logic [3:0] in_raw, lvl, rise, prev_q, prev_d;
    assign in_raw = {refund, quarter, dime, nickel};

`ifdef VEND_DEBOUNCE_EN
    // A level counts only once it was also high on the previous sample.
    logic [3:0] sync_q, sync_d;

    always_comb begin
        sync_d = in_raw;
        lvl    = in_raw & sync_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end
`else
    assign lvl = in_raw;
`endif

    logic [5:0] cents;
    logic [6:0] entry_d;
    logic       push;

    always_comb begin
        prev_d  = lvl;
        rise    = lvl & ~prev_q;
        push    = |rise;
        cents   = (lvl[0] ? 6'd5 : 6'd0) + (lvl[1] ? 6'd10 : 6'd0) + (lvl[2] ? 6'd25 : 6'd0);
        entry_d = {rise[3], cents};
    end

    logic [6:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, irq_q, irq_d;
    logic          empty, full, pop, push_ok;
    logic [6:0]    head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        pop      = mem_re && (sel == 2'd0) && !empty;
        // A pop frees a slot in the same cycle, so a full FIFO can still accept.
        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (wr_status && mem_wdata[0]) ovf_d = 1'b0;
        if (push && full && !pop)      ovf_d = 1'b1;
        irq_d = !empty;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= entry_d;
    end

    logic [PRODUCTS-1:0] vend_q, vend_d;
    logic [VW-1:0]       vcnt_q, vcnt_d;

    always_comb begin
        vend_d = vend_q;
        vcnt_d = vcnt_q;
        if (wr_vend) begin
            vend_d = mem_wdata[PRODUCTS-1:0];
            vcnt_d = VW'(TICK_DIV);
        end else if (vcnt_q != '0) begin
            vcnt_d = vcnt_q - VW'(1);
            if (vcnt_q == VW'(1)) vend_d = '0;
        end
    end

    disp_state_t state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic [2:0]  coin_q, coin_d;
    logic        busy;

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        coin_d  = coin_q;
        case (state_q)
            S_IDLE: begin
                if (wr_change) begin
                    rem_d   = mem_wdata[7:0];
                    state_d = S_WAIT;
                end
            end
            S_WAIT, S_GAP: begin
                if (tick) begin
                    state_d = S_EMIT;
                    if (rem_q >= 8'd25) begin
                        coin_d = 3'b100;
                        rem_d  = rem_q - 8'd25;
                    end else if (rem_q >= 8'd10) begin
                        coin_d = 3'b010;
                        rem_d  = rem_q - 8'd10;
                    end else if (rem_q >= 8'd5) begin
                        coin_d = 3'b001;
                        rem_d  = rem_q - 8'd5;
                    end else begin
                        // Sub-nickel residue cannot be paid out and is dropped.
                        state_d = S_IDLE;
                        rem_d   = '0;
                    end
                end
            end
            S_EMIT: begin
                if (tick) begin
                    coin_d  = '0;
                    state_d = S_GAP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            vend_q   <= '0;
            vcnt_q   <= '0;
            state_q  <= S_IDLE;
            rem_q    <= '0;
            coin_q   <= '0;
        end else begin
            div_q    <= div_d;
            prev_q   <= prev_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            vend_q   <= vend_d;
            vcnt_q   <= vcnt_d;
            state_q  <= state_d;
            rem_q    <= rem_d;
            coin_q   <= coin_d;
        end
    end

    logic [7:0] count8;
    assign count8 = 8'(count_q);

    always_comb begin
        mem_rdata = '0;
        case (sel)
            2'd0: if (!empty) mem_rdata = {head[6], 25'b0, head[5:0]};
            2'd1: mem_rdata = {16'b0, count8, 4'b0, busy, full, empty, ovf_q};
            2'd2: mem_rdata = {24'b0, rem_q};
            default: mem_rdata[PRODUCTS-1:0] = vend_q;
        endcase
    end

    assign nickel_out  = coin_q[0];
    assign dime_out    = coin_q[1];
    assign quarter_out = coin_q[2];
    assign vend        = vend_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_vend_mmio_bridge.sv
// Bench for vend_mmio_bridge: directed scenarios plus random traffic against a schedule-based reference model.
module tb_vend_mmio_bridge;

    localparam int DEPTH    = 4;
    localparam int PRODUCTS = 4;
    localparam int TICK_DIV = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                nickel, dime, quarter, refund;
    logic [31:0]         mem_addr, mem_wdata;
    logic                mem_we, mem_re;
    logic [31:0]         mem_rdata;
    logic                nickel_out, dime_out, quarter_out;
    logic [PRODUCTS-1:0] vend;
    logic                tick, irq;

    vend_mmio_bridge #(.DEPTH(DEPTH), .PRODUCTS(PRODUCTS), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .reset(reset),
        .nickel(nickel), .dime(dime), .quarter(quarter), .refund(refund),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .nickel_out(nickel_out), .dime_out(dime_out), .quarter_out(quarter_out),
        .vend(vend), .tick(tick), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, outputs derived from edge numbers since reset.
    logic [6:0]          q_m[$];
    bit                  ovf_m, irq_m;
    logic [3:0]          prev_m, sync_m;
    int                  ecnt;
    bit                  have_d;
    int                  t1, dend, amount;
    int                  coins[$];
    int                  vend_end;
    logic [PRODUCTS-1:0] vend_m;

    task automatic model_reset();
        q_m.delete();
        ovf_m = 0; irq_m = 0; prev_m = '0; sync_m = '0;
        ecnt = 0; have_d = 0; vend_end = 0; vend_m = '0;
    endtask

    task automatic schedule(input int c, input int amt);
        int r;
        have_d = 1;
        amount = amt;
        t1 = (c / TICK_DIV + 1) * TICK_DIV;
        coins.delete();
        r = amt;
        while (r >= 5) begin
            if (r >= 25)      begin coins.push_back(25); r -= 25; end
            else if (r >= 10) begin coins.push_back(10); r -= 10; end
            else              begin coins.push_back(5);  r -= 5;  end
        end
        dend = t1 + 2 * coins.size() * TICK_DIV;
    endtask

    function automatic bit busy_at(input int x);
        return have_d && (x < dend);
    endfunction

    function automatic int exp_coin(input int x);
        int j;
        if (!have_d || x < t1 || x >= dend) return 0;
        j = (x - t1) / TICK_DIV;
        if (j % 2 != 0) return 0;
        return coins[j / 2];
    endfunction

    function automatic int exp_rem(input int x);
        int k, r;
        if (!have_d || x >= dend) return 0;
        if (x < t1) return amount;
        k = (x - t1) / (2 * TICK_DIV);
        r = amount;
        for (int i = 0; i <= k && i < coins.size(); i++) r -= coins[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_rdata();
        logic [31:0] v;
        logic [6:0]  e;
        v = '0;
        case (mem_addr[3:2])
            2'd0: if (q_m.size() > 0) begin e = q_m[0]; v = {e[6], 25'b0, e[5:0]}; end
            2'd1: v = (32'(q_m.size()) << 8) | (32'(busy_at(ecnt)) << 3) |
                      (32'(q_m.size() == DEPTH) << 2) | (32'(q_m.size() == 0) << 1) | 32'(ovf_m);
            2'd2: v = 32'(exp_rem(ecnt));
            default: v = (ecnt < vend_end) ? 32'(vend_m) : 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_edge();
        int         x;
        bit         pop, busy_before;
        logic [3:0] in, lvl, rise;
        int         c;
        x = ecnt + 1;
        busy_before = busy_at(ecnt);
        pop = mem_re && (mem_addr[3:2] == 2'd0) && (q_m.size() > 0);
        irq_m = (q_m.size() > 0);
        in = {refund, quarter, dime, nickel};
`ifdef VEND_DEBOUNCE_EN
        lvl = in & sync_m;
`else
        lvl = in;
`endif
        sync_m = in;
        rise = lvl & ~prev_m;
        prev_m = lvl;
        c = 5 * int'(lvl[0]) + 10 * int'(lvl[1]) + 25 * int'(lvl[2]);
        if (mem_we && mem_addr[3:2] == 2'd1 && mem_wdata[0]) ovf_m = 0;
        if (pop) void'(q_m.pop_front());
        if (rise != 0) begin
            if (q_m.size() < DEPTH) q_m.push_back({rise[3], 6'(c)});
            else ovf_m = 1;
        end
        if (mem_we && mem_addr[3:2] == 2'd2 && !busy_before) schedule(x, int'(mem_wdata[7:0]));
        if (mem_we && mem_addr[3:2] == 2'd3) begin
            vend_m = mem_wdata[PRODUCTS-1:0];
            vend_end = x + TICK_DIV;
        end
        ecnt = x;
    endtask

    task automatic check_outputs();
        int c;
        c = exp_coin(ecnt);
        chk("quarter_out", 32'(quarter_out), 32'(c == 25));
        chk("dime_out", 32'(dime_out), 32'(c == 10));
        chk("nickel_out", 32'(nickel_out), 32'(c == 5));
        chk("tick", 32'(tick), 32'(ecnt % TICK_DIV == TICK_DIV - 1));
        chk("irq", 32'(irq), 32'(irq_m));
        chk("vend", 32'(vend), (ecnt < vend_end) ? 32'(vend_m) : 32'd0);
    endtask

    task automatic cycle();
        #1;
        chk("mem_rdata", mem_rdata, exp_rdata());
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_bus();
        mem_we = 0; mem_re = 0; mem_addr = '0; mem_wdata = '0;
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        mem_we = 1; mem_addr = 32'(idx) << 2; mem_wdata = d;
        cycle();
        idle_bus();
    endtask

    task automatic rd(input int idx, output logic [31:0] v);
        mem_re = 1; mem_addr = 32'(idx) << 2;
        #1 v = mem_rdata;
        cycle();
        idle_bus();
    endtask

    logic [31:0] v;
    int          qn, dn, nn, vn;

    initial begin
        reset = 1;
        nickel = 0; dime = 0; quarter = 0; refund = 0;
        idle_bus();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata_coin", mem_rdata, 32'd0);
        chk("rst_outs", {26'd0, quarter_out, dime_out, nickel_out, tick, irq, |vend}, 32'd0);
        @(negedge clk) reset = 0;

        // Single quarter pulse.
        quarter = 1; repeat (3) cycle();
        quarter = 0; cycle();
        chk("q25_irq", 32'(irq), 32'd1);
        rd(0, v); chk("q25_coin", v, 32'h19);
        rd(1, v); chk("q25_empty", 32'(v[1]), 32'd1); chk("q25_count", 32'(v[15:8]), 32'd0);

        // Nickel+dime together, then refund on top.
        nickel = 1; dime = 1; cycle();
        refund = 1; repeat (3) cycle();
        nickel = 0; dime = 0; refund = 0; repeat (2) cycle();
        rd(0, v); chk("nd_coin", v, 32'h0000000F);
        rd(0, v); chk("nd_refund", v, 32'h8000000F);

        // Overflow, ovf clear, push+pop while full.
        for (int i = 0; i < 5; i++) begin
            nickel = 1; repeat (2) cycle();
            nickel = 0; repeat (2) cycle();
        end
        rd(1, v); chk("ovf_status", v, 32'h00000405);
        wr(1, 32'h1);
        rd(1, v); chk("ovf_cleared", v, 32'h00000404);
        nickel = 1;
`ifdef VEND_DEBOUNCE_EN
        cycle();
`endif
        mem_re = 1; mem_addr = 32'h0;
        #1 v = mem_rdata; chk("full_pop_val", v, 32'h5);
        cycle(); idle_bus();
        nickel = 0; repeat (2) cycle();
        rd(1, v); chk("full_pushpop", v, 32'h00000404);
        for (int i = 0; i < DEPTH; i++) rd(0, v);

        // CHANGE 40 with an ignored mid-sequence write.
        wr(2, 32'd40);
        qn = 0; dn = 0; nn = 0;
        for (int i = 0; i < 400 && ecnt < dend + 2; i++) begin
            if (i == 40) begin mem_we = 1; mem_addr = 32'h8; mem_wdata = 32'd10; end
            else idle_bus();
            cycle();
            qn += int'(quarter_out); dn += int'(dime_out); nn += int'(nickel_out);
        end
        idle_bus();
        chk("chg40_quarter_cycles", 32'(qn), 32'd16);
        chk("chg40_dime_cycles", 32'(dn), 32'd16);
        chk("chg40_nickel_cycles", 32'(nn), 32'd16);
        rd(1, v); chk("chg40_busy", 32'(v[3]), 32'd0);

        // CHANGE 7, then VEND hold.
        wr(2, 32'd7);
        nn = 0;
        for (int i = 0; i < 200 && ecnt < dend + 2; i++) begin
            cycle(); nn += int'(nickel_out);
        end
        chk("chg7_nickel_cycles", 32'(nn), 32'd16);
        rd(2, v); chk("chg7_rem", v, 32'd0);
        wr(3, 32'h1);
        vn = 0;
        for (int i = 0; i < 20; i++) begin vn += int'(vend[0]); cycle(); end
        chk("vend_hold", 32'(vn), 32'd16);

        // Async reset during EMIT.
        wr(2, 32'd40);
        nickel = 1; cycle(); nickel = 0;
        for (int i = 0; i < 100 && ecnt < t1 + 3; i++) cycle();
        chk("pre_reset_quarter", 32'(quarter_out), 32'd1);
        #2 reset = 1;
        #1;
        chk("rst_async_coins", {29'd0, quarter_out, dime_out, nickel_out}, 32'd0);
        chk("rst_async_irq", 32'(irq), 32'd0);
        model_reset();
        @(negedge clk) reset = 0;

`ifdef VEND_DEBOUNCE_EN
        dime = 1; cycle(); dime = 0; repeat (3) cycle();
        rd(1, v); chk("glitch_count", 32'(v[15:8]), 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) nickel  = ~nickel;
            if ($urandom_range(0, 7) == 0) dime    = ~dime;
            if ($urandom_range(0, 7) == 0) quarter = ~quarter;
            if ($urandom_range(0, 11) == 0) refund = ~refund;
            idle_bus();
            if ($urandom_range(0, 3) == 0) begin
                mem_addr  = {$urandom, 2'b00} & 32'hFFFF_FFFC;
                mem_addr[1:0] = 2'($urandom);
                mem_wdata = $urandom;
                if (mem_addr[3:2] == 2'd2) mem_wdata[7:0] = 8'($urandom_range(0, 120));
                if ($urandom_range(0, 1) == 0) mem_we = 1;
                else mem_re = 1;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
